// File: rtl/intpol2_iq_stream_ctrl_if.sv
// Sample path between the frame sequencer, its upstream I/Q source and the interpolator write port.
// The controller takes the slave view; the environment around it takes the master view.
interface intpol2_iq_stream_ctrl_if #(
    parameter int DATAPATH_WIDTH = 32
);
    logic                      src_valid;
    logic                      src_ready;
    logic [DATAPATH_WIDTH-1:0] src_I;
    logic [DATAPATH_WIDTH-1:0] src_Q;

    logic                      ip_we;
    logic [DATAPATH_WIDTH-1:0] ip_I;
    logic [DATAPATH_WIDTH-1:0] ip_Q;
    logic                      ip_afull_I;
    logic                      ip_afull_Q;
    logic                      ip_done;

    modport slave (
        input  src_valid, src_I, src_Q, ip_afull_I, ip_afull_Q, ip_done,
        output src_ready, ip_we, ip_I, ip_Q
    );

    modport master (
        output src_valid, src_I, src_Q, ip_afull_I, ip_afull_Q, ip_done,
        input  src_ready, ip_we, ip_I, ip_Q
    );
endinterface

// File: rtl/intpol2_iq_stream_ctrl.sv
// Frame sequencer in front of the IQ interpolator: forwards one frame of I/Q samples,
// waits for the interpolator's done with a timeout, then raises a sticky interrupt.
module intpol2_iq_stream_ctrl #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic                 cfg_irq_clr,
    input  logic [CNT_WIDTH-1:0] cfg_frame_len,
    intpol2_iq_stream_ctrl_if.slave bus,
    output logic                 stat_busy,
    output logic [CNT_WIDTH-1:0] stat_count,
    output logic                 stat_err,
    output logic                 irq
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_DONE,
        DONE
    } ctrlState_e;

    ctrlState_e           state;
    logic [CNT_WIDTH-1:0] frameLen;
    logic [CNT_WIDTH-1:0] countNext;
    logic [TW-1:0]        timeoutCnt;
    logic                 srcReady;
    logic                 transfer;
    logic                 lastTransfer;
    logic                 timeoutHit;

    // Either almost-full flag stalls the source in the very same cycle.
    assign srcReady      = (state == RUN) & ~bus.ip_afull_I & ~bus.ip_afull_Q;
    assign transfer      = bus.src_valid & srcReady;
    assign countNext     = stat_count + CNT_WIDTH'(1);
    assign lastTransfer  = transfer & (countNext == frameLen);
    assign timeoutHit    = (timeoutCnt == TW'(TIMEOUT_CYCLES - 1));
    assign bus.src_ready = srcReady;
    assign stat_busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            frameLen   <= '0;
            timeoutCnt <= '0;
            stat_count <= '0;
            stat_err   <= 1'b0;
            irq        <= 1'b0;
            bus.ip_we  <= 1'b0;
            bus.ip_I   <= '0;
            bus.ip_Q   <= '0;
        end else begin
            bus.ip_we <= transfer;
            if (transfer) begin
                bus.ip_I <= bus.src_I;
                bus.ip_Q <= bus.src_Q;
                if (stat_count != frameLen) begin
                    stat_count <= countNext;
                end
            end

            // Clear comes first so that a set in the same cycle overrides it.
            if (cfg_irq_clr) begin
                irq      <= 1'b0;
                stat_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        frameLen   <= cfg_frame_len;
                        stat_count <= '0;
                        timeoutCnt <= '0;
                        state      <= (cfg_frame_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                    end else if (lastTransfer) begin
                        timeoutCnt <= '0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                    end else if (bus.ip_done) begin
                        state <= DONE;
                    end else if (timeoutHit) begin
                        stat_err <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timeoutCnt <= timeoutCnt + TW'(1);
                    end
                end
                DONE: begin
                    irq   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intpol2_iq_stream_ctrl.sv
// Directed bench for intpol2_iq_stream_ctrl: a frame-level model predicts every output each cycle,
// and literal expectations at key points pin the model to hand-derived values.
module tb_intpol2_iq_stream_ctrl;

    localparam int DW      = 32;
    localparam int CW      = 16;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfgStart;
    logic          cfgAbort;
    logic          cfgIrqClr;
    logic [CW-1:0] cfgFrameLen;
    logic          statBusy;
    logic [CW-1:0] statCount;
    logic          statErr;
    logic          irq;

    int checks = 0;
    int errors = 0;
    int writesSeen = 0;
    int srcIdx = 0;
    bit checkEn = 1'b0;

    intpol2_iq_stream_ctrl_if #(.DATAPATH_WIDTH(DW)) bus ();

    intpol2_iq_stream_ctrl #(
        .DATAPATH_WIDTH(DW),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfgStart),
        .cfg_abort    (cfgAbort),
        .cfg_irq_clr  (cfgIrqClr),
        .cfg_frame_len(cfgFrameLen),
        .bus          (bus),
        .stat_busy    (statBusy),
        .stat_count   (statCount),
        .stat_err     (statErr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkI(input int n);
        return 32'hA000_0000 | 32'(n);
    endfunction

    function automatic logic [DW-1:0] mkQ(input int n);
        return 32'h5000_0000 + 32'(n * 3);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: what the frame should look like, tracked as phase, samples left and wait time.
    typedef enum int {PH_IDLE, PH_STREAM, PH_DRAIN, PH_FINISH} phase_e;
    phase_e        phase = PH_IDLE;
    int            mLen = 0;
    int            left = 0;
    int            waited = 0;
    logic          mWe = 1'b0;
    logic [DW-1:0] mI = '0;
    logic [DW-1:0] mQ = '0;
    logic          mErr = 1'b0;
    logic          mIrq = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (!rst) begin
            phase = PH_IDLE;
            mLen = 0; left = 0; waited = 0;
            mWe = 1'b0; mI = '0; mQ = '0; mErr = 1'b0; mIrq = 1'b0;
        end else begin
            acc = (phase == PH_STREAM) && bus.src_valid && !bus.ip_afull_I && !bus.ip_afull_Q;
            mWe = acc;
            if (acc) begin
                mI = bus.src_I;
                mQ = bus.src_Q;
                left--;
                srcIdx++;
            end
            if (cfgIrqClr) begin
                mIrq = 1'b0;
                mErr = 1'b0;
            end
            case (phase)
                PH_IDLE: if (cfgStart && !cfgAbort) begin
                    mLen = int'(cfgFrameLen);
                    left = mLen;
                    phase = (mLen == 0) ? PH_FINISH : PH_STREAM;
                end
                PH_STREAM: begin
                    if (cfgAbort) phase = PH_IDLE;
                    else if (acc && left == 0) begin
                        waited = 0;
                        phase = PH_DRAIN;
                    end
                end
                PH_DRAIN: begin
                    waited++;
                    if (cfgAbort) phase = PH_IDLE;
                    else if (bus.ip_done) phase = PH_FINISH;
                    else if (waited == TIMEOUT) begin
                        mErr = 1'b1;
                        phase = PH_FINISH;
                    end
                end
                PH_FINISH: begin
                    mIrq = 1'b1;
                    phase = PH_IDLE;
                end
                default: phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            if (bus.ip_we === 1'b1) writesSeen++;
            checkOutput("src_ready", 64'(bus.src_ready),
                        64'((phase == PH_STREAM) && !bus.ip_afull_I && !bus.ip_afull_Q));
            checkOutput("ip_we", 64'(bus.ip_we), 64'(mWe));
            checkOutput("ip_I", 64'(bus.ip_I), 64'(mI));
            checkOutput("ip_Q", 64'(bus.ip_Q), 64'(mQ));
            checkOutput("stat_busy", 64'(statBusy), 64'(phase != PH_IDLE));
            checkOutput("stat_count", 64'(statCount), 64'(CW'(mLen - left)));
            checkOutput("stat_err", 64'(statErr), 64'(mErr));
            checkOutput("irq", 64'(irq), 64'(mIrq));
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            bus.src_I = mkI(srcIdx);
            bus.src_Q = mkQ(srcIdx);
        end
    endtask

    task automatic pulseStart(input int len);
        cfgFrameLen = CW'(len);
        cfgStart = 1'b1;
        applyStimulus(1);
        cfgStart = 1'b0;
    endtask

    task automatic finishWithDone();
        bus.ip_done = 1'b1;
        applyStimulus(1);
        bus.ip_done = 1'b0;
        applyStimulus(1);
    endtask

    task automatic clearIrq();
        cfgIrqClr = 1'b1;
        applyStimulus(1);
        cfgIrqClr = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b0;
        cfgStart = 1'b0; cfgAbort = 1'b0; cfgIrqClr = 1'b0; cfgFrameLen = '0;
        bus.src_valid = 1'b0; bus.src_I = mkI(0); bus.src_Q = mkQ(0);
        bus.ip_afull_I = 1'b0; bus.ip_afull_Q = 1'b0; bus.ip_done = 1'b0;
        applyStimulus(2);
        rst = 1'b1;
        checkEn = 1'b1;

        checkOutput("reset busy", 64'(statBusy), 64'd0);
        checkOutput("reset count", 64'(statCount), 64'd0);
        checkOutput("reset irq", 64'(irq), 64'd0);
        checkOutput("reset ip_we", 64'(bus.ip_we), 64'd0);
        checkOutput("reset ip_I", 64'(bus.ip_I), 64'd0);

        // Basic 4-sample frame, done three cycles after the last write.
        writesSeen = 0;
        base = srcIdx;
        bus.src_valid = 1'b1;
        pulseStart(4);
        checkOutput("basic busy", 64'(statBusy), 64'd1);
        applyStimulus(1);
        checkOutput("basic first we", 64'(bus.ip_we), 64'd1);
        checkOutput("basic D0", 64'(bus.ip_I), 64'(mkI(base)));
        applyStimulus(3);
        checkOutput("basic D3", 64'(bus.ip_Q), 64'(mkQ(base + 3)));
        checkOutput("basic count", 64'(statCount), 64'd4);
        applyStimulus(3);
        finishWithDone();
        checkOutput("basic irq", 64'(irq), 64'd1);
        checkOutput("basic idle", 64'(statBusy), 64'd0);
        checkOutput("basic writes", 64'(writesSeen), 64'd4);
        clearIrq();
        checkOutput("basic irq clr", 64'(irq), 64'd0);

        // Back-pressure: afull_I in RUN cycles 3..5, afull_Q in cycle 8.
        writesSeen = 0;
        pulseStart(6);
        for (int k = 0; k < 10; k++) begin
            bus.ip_afull_I = (k >= 3 && k <= 5);
            bus.ip_afull_Q = (k == 8);
            #1;
            checkOutput("bp ready", 64'(bus.src_ready), 64'((k < 3 || k > 5) && k != 8));
            applyStimulus(1);
        end
        bus.ip_afull_I = 1'b0;
        bus.ip_afull_Q = 1'b0;
        checkOutput("bp ready after last", 64'(bus.src_ready), 64'd0);
        checkOutput("bp count", 64'(statCount), 64'd6);
        finishWithDone();
        checkOutput("bp writes", 64'(writesSeen), 64'd6);
        checkOutput("bp irq", 64'(irq), 64'd1);
        clearIrq();

        // Timeout: done never arrives, DONE is reached 8 cycles after entering WAIT_DONE.
        pulseStart(2);
        applyStimulus(2);
        applyStimulus(7);
        checkOutput("to err early", 64'(statErr), 64'd0);
        checkOutput("to busy", 64'(statBusy), 64'd1);
        applyStimulus(1);
        checkOutput("to err set", 64'(statErr), 64'd1);
        applyStimulus(1);
        checkOutput("to irq", 64'(irq), 64'd1);
        checkOutput("to idle", 64'(statBusy), 64'd0);
        clearIrq();
        checkOutput("to irq clr", 64'(irq), 64'd0);
        checkOutput("to err clr", 64'(statErr), 64'd0);

        // Abort after five transfers, then a fresh frame is accepted.
        pulseStart(10);
        applyStimulus(5);
        checkOutput("abort count pre", 64'(statCount), 64'd5);
        bus.src_valid = 1'b0;
        cfgAbort = 1'b1;
        applyStimulus(1);
        cfgAbort = 1'b0;
        checkOutput("abort ready", 64'(bus.src_ready), 64'd0);
        checkOutput("abort busy", 64'(statBusy), 64'd0);
        applyStimulus(3);
        checkOutput("abort count", 64'(statCount), 64'd5);
        checkOutput("abort irq", 64'(irq), 64'd0);
        bus.src_valid = 1'b1;
        pulseStart(3);
        checkOutput("restart busy", 64'(statBusy), 64'd1);
        checkOutput("restart count", 64'(statCount), 64'd0);
        applyStimulus(3);
        checkOutput("restart count end", 64'(statCount), 64'd3);
        finishWithDone();
        checkOutput("restart irq", 64'(irq), 64'd1);
        clearIrq();

        // Zero-length frame: straight to DONE, no writes.
        writesSeen = 0;
        pulseStart(0);
        checkOutput("len0 busy", 64'(statBusy), 64'd1);
        checkOutput("len0 ready", 64'(bus.src_ready), 64'd0);
        applyStimulus(1);
        checkOutput("len0 irq", 64'(irq), 64'd1);
        checkOutput("len0 idle", 64'(statBusy), 64'd0);
        checkOutput("len0 writes", 64'(writesSeen), 64'd0);
        clearIrq();

        // A start during RUN must not change the latched length.
        pulseStart(3);
        applyStimulus(1);
        cfgFrameLen = CW'(7);
        cfgStart = 1'b1;
        applyStimulus(1);
        cfgStart = 1'b0;
        applyStimulus(1);
        checkOutput("busy start ready", 64'(bus.src_ready), 64'd0);
        checkOutput("busy start count", 64'(statCount), 64'd3);
        finishWithDone();
        clearIrq();

        // Start and abort together in IDLE: abort wins.
        cfgFrameLen = CW'(5);
        cfgStart = 1'b1;
        cfgAbort = 1'b1;
        applyStimulus(1);
        cfgStart = 1'b0;
        cfgAbort = 1'b0;
        checkOutput("start+abort busy", 64'(statBusy), 64'd0);
        applyStimulus(1);
        checkOutput("start+abort count", 64'(statCount), 64'd3);

        // Reset while waiting for done; a late done must not raise irq.
        pulseStart(1);
        applyStimulus(1);
        bus.src_valid = 1'b0;
        applyStimulus(1);
        checkOutput("rst pre busy", 64'(statBusy), 64'd1);
        rst = 1'b0;
        applyStimulus(1);
        rst = 1'b1;
        checkOutput("rst busy", 64'(statBusy), 64'd0);
        checkOutput("rst count", 64'(statCount), 64'd0);
        checkOutput("rst ip_I", 64'(bus.ip_I), 64'd0);
        checkOutput("rst we", 64'(bus.ip_we), 64'd0);
        finishWithDone();
        applyStimulus(1);
        checkOutput("rst late done irq", 64'(irq), 64'd0);
        checkOutput("rst late done busy", 64'(statBusy), 64'd0);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
